// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store initiator: width codes, FSM states,
// and small decode helpers used at request acceptance.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        SPLIT  = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    function automatic logic [2:0] bytes_for(input logic [2:0] funct3);
        logic [2:0] n;
        case (funct3[1:0])
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            2'b10:   n = 3'd4;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        if (we) begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        end
        return ok;
    endfunction

    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] lsb);
        logic ok;
        case (bytes_for(funct3))
            3'd2:    ok = (lsb[0] == 1'b0);
            3'd4:    ok = (lsb == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of a little-endian load value according to its width code.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] raw_i,
    output logic [31:0] ext_o
);

    // Select the extension rule for the width code; words pass through
    always_comb begin
        ext_o = raw_i;
        case (funct3_i)
            F3_B:    ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
            F3_BU:   ext_o = {24'h000000, raw_i[7:0]};
            F3_H:    ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
            F3_HU:   ext_o = {16'h0000, raw_i[15:0]};
            default: ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one request at a time, aligned accesses in one memory
// cycle, misaligned half/word split into byte accesses and reassembled.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int ADDR_W           = 8,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        idx_q;
    logic [31:0]       result_q;

    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_fault_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [2:0]        mem_funct3_q;

    logic              hs_s;
    logic              legal_s;
    logic              aligned_s;
    logic              last_s;
    logic [1:0]        next_idx_s;
    logic [ADDR_W-1:0] split_addr_s;
    logic [7:0]        split_byte_s;
    logic [31:0]       assembled_s;
    logic [31:0]       extended_s;

    assign hs_s         = req_valid && req_ready_q;
    assign legal_s      = is_legal(req_we, req_funct3);
    assign aligned_s    = is_aligned(req_funct3, req_addr[1:0]);
    assign last_s       = ({1'b0, idx_q} == (bytes_for(funct3_q) - 3'd1));
    assign next_idx_s   = idx_q + 2'd1;
    assign split_addr_s = addr_q + ADDR_W'(next_idx_s);
    assign split_byte_s = byte_of(wdata_q, next_idx_s);

    // Merge the byte returned this split cycle into its lane of the result
    always_comb begin
        assembled_s = result_q;
        case (idx_q)
            2'd0:    assembled_s[7:0]   = mem_rdata[7:0];
            2'd1:    assembled_s[15:8]  = mem_rdata[7:0];
            2'd2:    assembled_s[23:16] = mem_rdata[7:0];
            default: assembled_s[31:24] = mem_rdata[7:0];
        endcase
    end

    lsu_load_extend u_extend (
        .funct3_i (funct3_q),
        .raw_i    (assembled_s),
        .ext_o    (extended_s)
    );

    // Request FSM with registered handshake, response and memory-port outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= 32'h0000_0000;
            idx_q        <= 2'd0;
            result_q     <= 32'h0000_0000;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0000_0000;
            rsp_fault_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0000_0000;
            mem_funct3_q <= 3'b000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs_s) begin
                        we_q        <= req_we;
                        funct3_q    <= req_funct3;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        idx_q       <= 2'd0;
                        result_q    <= 32'h0000_0000;
                        req_ready_q <= 1'b0;
                        if (!legal_s || (!aligned_s && (SPLIT_MISALIGNED == 1'b0))) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_fault_q <= 1'b1;
                            rsp_rdata_q <= 32'h0000_0000;
                        end else if (aligned_s) begin
                            state_q      <= ACCESS;
                            mem_read_q   <= !req_we;
                            mem_write_q  <= req_we;
                            mem_addr_q   <= req_addr;
                            mem_funct3_q <= req_funct3;
                            mem_wdata_q  <= req_wdata;
                        end else begin
                            state_q      <= SPLIT;
                            mem_read_q   <= !req_we;
                            mem_write_q  <= req_we;
                            mem_addr_q   <= req_addr;
                            mem_funct3_q <= req_we ? F3_B : F3_BU;
                            mem_wdata_q  <= req_we ? {24'h000000, req_wdata[7:0]} : 32'h0000_0000;
                        end
                    end else begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                ACCESS: begin
                    result_q     <= we_q ? 32'h0000_0000 : mem_rdata;
                    rsp_rdata_q  <= we_q ? 32'h0000_0000 : mem_rdata;
                    rsp_valid_q  <= 1'b1;
                    rsp_fault_q  <= 1'b0;
                    mem_read_q   <= 1'b0;
                    mem_write_q  <= 1'b0;
                    mem_addr_q   <= '0;
                    mem_wdata_q  <= 32'h0000_0000;
                    mem_funct3_q <= 3'b000;
                    state_q      <= RESP;
                end
                SPLIT: begin
                    if (last_s) begin
                        result_q     <= we_q ? 32'h0000_0000 : extended_s;
                        rsp_rdata_q  <= we_q ? 32'h0000_0000 : extended_s;
                        rsp_valid_q  <= 1'b1;
                        rsp_fault_q  <= 1'b0;
                        mem_read_q   <= 1'b0;
                        mem_write_q  <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_wdata_q  <= 32'h0000_0000;
                        mem_funct3_q <= 3'b000;
                        state_q      <= RESP;
                    end else begin
                        result_q    <= we_q ? 32'h0000_0000 : assembled_s;
                        idx_q       <= next_idx_s;
                        mem_addr_q  <= split_addr_s;
                        mem_wdata_q <= we_q ? {24'h000000, split_byte_s} : 32'h0000_0000;
                        state_q     <= SPLIT;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= 32'h0000_0000;
                    rsp_fault_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    rsp_valid_q  <= 1'b0;
                    rsp_rdata_q  <= 32'h0000_0000;
                    rsp_fault_q  <= 1'b0;
                    mem_read_q   <= 1'b0;
                    mem_write_q  <= 1'b0;
                    mem_addr_q   <= '0;
                    mem_wdata_q  <= 32'h0000_0000;
                    mem_funct3_q <= 3'b000;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_fault  = rsp_fault_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_funct3 = mem_funct3_q;

endmodule
